// File: rtl/ic_partition_sched.sv
// Stage-1 source-partition scheduler.
// Grants one partition per enabled cycle with rotating priority, urgent
// requests first, and registers a stage-2 descriptor for the data mux.
module ic_partition_sched #(
  parameter int NPART = 4,
  parameter int IDXW  = 2,
  parameter int CNTW  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [NPART-1:0] part_valid,
  input  logic [NPART-1:0] part_valid_urgent,
  input  logic [NPART-1:0] part_can_increment,
  output logic [NPART-1:0] part_select,
  output logic             s2_valid,
  output logic [IDXW-1:0]  s2_part,
  output logic [IDXW-1:0]  rr_ptr,
  output logic [CNTW-1:0]  grant_count
);

  // One extra bit so pointer + offset never overflows before the wrap.
  localparam int              SW       = IDXW + 1;
  localparam logic [SW-1:0]   NPART_W  = SW'(NPART);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NPART - 1);

  logic [IDXW-1:0]  rr_ptr_reg, rr_ptr_next;
  logic             s2_valid_reg, s2_valid_next;
  logic [IDXW-1:0]  s2_part_reg, s2_part_next;
  logic [CNTW-1:0]  grant_count_reg, grant_count_next;

  logic [NPART-1:0] urgent_req;
  logic             urgent_hit, normal_hit;
  logic [IDXW-1:0]  urgent_idx, normal_idx;
  logic [SW-1:0]    cand_sum;
  logic             grant_any;
  logic             grant_fire;
  logic [IDXW-1:0]  grant_idx;

  // Urgent flag only counts when the partition actually has a flit.
  assign urgent_req = part_valid & part_valid_urgent;

  // Walk the partitions from rr_ptr upward with wrap; remember the first
  // urgent and the first plain requester met along the way.
  always_comb begin
    urgent_hit = 1'b0;
    normal_hit = 1'b0;
    urgent_idx = '0;
    normal_idx = '0;
    cand_sum   = '0;
    for (int k = 0; k < NPART; k++) begin
      cand_sum = {1'b0, rr_ptr_reg} + SW'(k);
      if (cand_sum >= NPART_W) begin
        cand_sum = cand_sum - NPART_W;
      end
      if (!urgent_hit && urgent_req[cand_sum[IDXW-1:0]]) begin
        urgent_hit = 1'b1;
        urgent_idx = cand_sum[IDXW-1:0];
      end
      if (!normal_hit && part_valid[cand_sum[IDXW-1:0]]) begin
        normal_hit = 1'b1;
        normal_idx = cand_sum[IDXW-1:0];
      end
    end
  end

  assign grant_any  = urgent_hit | normal_hit;
  assign grant_idx  = urgent_hit ? urgent_idx : normal_idx;
  assign grant_fire = enable & grant_any;

  // One-hot select; forced low while reset is held so no partition dequeues.
  generate
    for (genvar gi = 0; gi < NPART; gi++) begin : g_select
      assign part_select[gi] = grant_fire && !reset && (grant_idx == IDXW'(gi));
    end
  endgenerate

  // Next-state: pointer advance or re-favour, stage-2 descriptor, statistics.
  always_comb begin
    rr_ptr_next      = rr_ptr_reg;
    s2_valid_next    = s2_valid_reg;
    s2_part_next     = s2_part_reg;
    grant_count_next = grant_count_reg;
    if (grant_fire) begin
      s2_valid_next = 1'b1;
      s2_part_next  = grant_idx;
      if (part_can_increment[grant_idx]) begin
        rr_ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDXW'(1);
      end else begin
        // Partition could not advance: keep it at the head of the rotation.
        rr_ptr_next = grant_idx;
      end
      if (grant_count_reg != '1) begin
        grant_count_next = grant_count_reg + CNTW'(1);
      end
    end else if (enable) begin
      s2_valid_next = 1'b0;
    end
  end

  // State registers with immediate clear on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_reg      <= '0;
      s2_valid_reg    <= 1'b0;
      s2_part_reg     <= '0;
      grant_count_reg <= '0;
    end else begin
      rr_ptr_reg      <= rr_ptr_next;
      s2_valid_reg    <= s2_valid_next;
      s2_part_reg     <= s2_part_next;
      grant_count_reg <= grant_count_next;
    end
  end

  assign rr_ptr      = rr_ptr_reg;
  assign s2_valid    = s2_valid_reg;
  assign s2_part     = s2_part_reg;
  assign grant_count = grant_count_reg;

endmodule

// File: doc/ic_partition_sched.md
# ic_partition_sched

Stage-1 scheduler for the interconnect source partitions. Each enabled cycle it grants one of `NPART` source partitions using rotating priority, with urgent requests served first. The grant drives each partition's `select` input. A registered stage-2 descriptor (index plus valid) steers the downstream stage-2 data mux. The rotation pointer advances only when the granted partition reports `can_increment`, so a partition holding urgent traffic keeps priority until it drains.

## Interface
- `NPART`, default 4: number of source partitions; must be ≥ 2 and need not be a power of two.
- `IDXW`, default 2: width of partition index; equals ceil(log2(NPART)).
- `CNTW`, default 16: width of the grant statistics counter.

Ports:
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `enable` in 1: simulator step enable; when low, no grant is issued and no state changes.
- `part_valid` in NPART: bit i set means partition i has a flit (its `s1_valid`).
- `part_valid_urgent` in NPART: bit i is partition i's `s1_valid_urgent`; ignored unless the matching `part_valid` bit is set.
- `part_can_increment` in NPART: bit i is partition i's `can_increment`.
- `part_select` out NPART: one-hot grant, combinational, same cycle as request; all-zero when there is no grant.
- `s2_valid` out 1: registered; the stage-2 slot holds a granted flit.
- `s2_part` out IDXW: registered index of the partition granted one cycle earlier.
- `rr_ptr` out IDXW: current rotation pointer (registered).
- `grant_count` out CNTW: saturating count of grants issued.

## Operation
- Effective urgent request: `u = part_valid & part_valid_urgent`.
- Grant search uses rotating priority starting at `rr_ptr`, ascending with wrap from NPART-1 to 0:
  - if `u` is nonzero, grant the first set bit of `u`;
  - else if `part_valid` is nonzero, grant the first set bit of `part_valid`;
  - else no grant.
- `part_select` is the one-hot of the grant index `g`, gated by `enable`. At most one bit is ever set.
- Pointer update happens on an enabled cycle with a grant:
  - if `part_can_increment[g]` is 1: `rr_ptr <= (g == NPART-1) ? 0 : g+1`;
  - if `part_can_increment[g]` is 0: `rr_ptr <= g`, so the urgent partition is re-favoured next cycle.
- No grant, or `enable` low: `rr_ptr` holds.
- Stage-2 register, on enabled cycles only: `s2_valid <= (grant)` and `s2_part <= g` (`s2_part` holds its old value when there is no grant). When `enable` is low, both hold.
- `grant_count` increments by 1 per enabled grant and saturates at all-ones; it never wraps.
- Indices ≥ NPART are unreachable. `rr_ptr` never takes a value ≥ NPART.

## Timing
- Grant latency: 0 cycles. `part_select` follows the request inputs combinationally, and the partition dequeues in the same cycle.
- Stage-2 latency: `s2_valid`/`s2_part` appear 1 cycle after the grant cycle, aligned with the partition's stage-2 pipeline register.
- Reset values: `rr_ptr`=0, `s2_valid`=0, `s2_part`=0, `grant_count`=0. `part_select`=0 while `reset` is high.
- Reset asserted mid-operation clears everything asynchronously. The first grant after release searches from index 0.
- `enable` falling while requests are pending: `part_select` goes to 0 that cycle; state is frozen and resumes unchanged when `enable` returns.
- Simultaneous urgent and normal requests: urgent always wins, regardless of pointer position.
- Wrap: a grant to NPART-1 with `can_increment`=1 sets `rr_ptr`=0.

## Test plan
- Reset, then `enable`=1 with `part_valid`=4'b1111 and all `can_increment`=1 held for 5 cycles → `part_select` sequence 0001, 0010, 0100, 1000, 0001; `s2_part` lags by 1 cycle; `grant_count`=5.
- `rr_ptr`=1, `part_valid`=4'b1011, `part_valid_urgent`=4'b1000 → grant 1000. Then repeat with `can_increment[3]`=0 → `rr_ptr` stays at 3 and partition 3 is granted again.
- `part_valid`=0 for 3 cycles → `part_select`=0, `s2_valid`=0 after 1 cycle, `rr_ptr` and `grant_count` unchanged.
- `enable` toggled low for 2 cycles with `part_valid`=4'b0110 → no select, `s2_valid`/`s2_part`/`rr_ptr` frozen. Resume → grant continues from the frozen pointer.
- `reset` pulsed asynchronously between clock edges while `rr_ptr`=2 and `s2_valid`=1 → all outputs 0 immediately. After release, `part_valid`=4'b1111 grants 0001.
- CNTW=3: 9 consecutive grants → `grant_count` reads 7 and holds at 7.
